// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline: operand-demand vs producer-
// supply hazard detection, mult/div occupancy tracking, and an exception/ERET
// redirect FSM that clears the FD/DE/ExMem registers and steers the PC.
module pipe_hazard_ctrl #(
  parameter int unsigned MULT_LAT = 5,
  parameter int unsigned DIV_LAT  = 10,
  parameter logic [31:0] HANDLER  = 32'h0000_4180
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [4:0]  grfRa1_D,
  input  logic [4:0]  grfRa2_D,
  input  logic        ifReGrf1_D,
  input  logic        ifReGrf2_D,
  input  logic [4:0]  tUseRs_D,
  input  logic [4:0]  tUseRt_D,
  input  logic [4:0]  grfWa_Ex,
  input  logic [4:0]  grfWa_Mem,
  input  logic        ifWrGrf_Ex,
  input  logic        ifWrGrf_Mem,
  input  logic [4:0]  tNew_Ex,
  input  logic [4:0]  tNew_Mem,
  input  logic        mdUse_D,
  input  logic        mdStart_Ex,
  input  logic        mdIsDiv_Ex,
  input  logic        excReq_Mem,
  input  logic        eret_Mem,
  input  logic [31:0] epc,
  output logic        stall_F,
  output logic        stall_D,
  output logic        flush_D,
  output logic        flush_Ex,
  output logic        flush_Mem,
  output logic        redirect,
  output logic [31:0] redirectPc,
  output logic        mdBusy
);

  localparam int unsigned MAXLAT = (DIV_LAT > MULT_LAT) ? DIV_LAT : MULT_LAT;
  localparam int unsigned CW     = $clog2(MAXLAT + 1);

  typedef enum logic [0:0] {RUN, REDIR} state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] mdCnt_q, mdCnt_d;

  logic stallRs, stallRt, stallMd, stall;
  logic kill, mdStartEff, mdBusyInt;

  // Hazard detection, kill decode and md occupancy.
  always_comb begin
    stallRs = ifReGrf1_D && (grfRa1_D != 5'd0) &&
              ((ifWrGrf_Ex  && (grfWa_Ex  == grfRa1_D) && (tNew_Ex  > tUseRs_D)) ||
               (ifWrGrf_Mem && (grfWa_Mem == grfRa1_D) && (tNew_Mem > tUseRs_D)));
    stallRt = ifReGrf2_D && (grfRa2_D != 5'd0) &&
              ((ifWrGrf_Ex  && (grfWa_Ex  == grfRa2_D) && (tNew_Ex  > tUseRt_D)) ||
               (ifWrGrf_Mem && (grfWa_Mem == grfRa2_D) && (tNew_Mem > tUseRt_D)));
    kill       = (state_q == RUN) && (excReq_Mem || eret_Mem);
    mdStartEff = mdStart_Ex && !kill;
    mdBusyInt  = (mdCnt_q != '0) || mdStartEff;
    stallMd    = mdUse_D && mdBusyInt;
    stall      = stallRs || stallRt || stallMd;
  end

  // Output generation: kill overrides stall; everything is held low in reset.
  always_comb begin
    stall_F    = 1'b0;
    stall_D    = 1'b0;
    flush_D    = 1'b0;
    flush_Ex   = 1'b0;
    flush_Mem  = 1'b0;
    redirect   = 1'b0;
    redirectPc = '0;
    mdBusy     = 1'b0;
    if (!reset) begin
      mdBusy = mdBusyInt;
      if (kill) begin
        flush_D    = 1'b1;
        flush_Ex   = 1'b1;
        flush_Mem  = 1'b1;
        redirect   = 1'b1;
        redirectPc = excReq_Mem ? HANDLER : epc;
      end else if (stall) begin
        stall_F  = 1'b1;
        stall_D  = 1'b1;
        flush_Ex = 1'b1;
      end
    end
  end

  // Next-state for the redirect FSM and the md busy counter.
  always_comb begin
    state_d = state_q;
    case (state_q)
      RUN:     if (kill) state_d = REDIR;
      REDIR:   state_d = RUN;
      default: state_d = RUN;
    endcase

    mdCnt_d = mdCnt_q;
    if (mdStartEff)
      mdCnt_d = mdIsDiv_Ex ? CW'(DIV_LAT) : CW'(MULT_LAT);
    else if (mdCnt_q != '0)
      mdCnt_d = mdCnt_q - CW'(1);
  end

  // State and counter registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= RUN;
      mdCnt_q <= '0;
    end else begin
      state_q <= state_d;
      mdCnt_q <= mdCnt_d;
    end
  end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed scoreboard bench for pipe_hazard_ctrl: stimulus pushes hand-computed
// expected outputs into a queue; a negedge monitor pops and compares.
module tb_pipe_hazard_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic [4:0]  grfRa1_D, grfRa2_D, tUseRs_D, tUseRt_D;
  logic        ifReGrf1_D, ifReGrf2_D;
  logic [4:0]  grfWa_Ex, grfWa_Mem, tNew_Ex, tNew_Mem;
  logic        ifWrGrf_Ex, ifWrGrf_Mem;
  logic        mdUse_D, mdStart_Ex, mdIsDiv_Ex, excReq_Mem, eret_Mem;
  logic [31:0] epc;
  logic        stall_F, stall_D, flush_D, flush_Ex, flush_Mem, redirect, mdBusy;
  logic [31:0] redirectPc;

  int checks   = 0;
  int failures = 0;

  logic [38:0] exp_q[$];
  string       name_q[$];

  always #5 clk = ~clk;

  pipe_hazard_ctrl #(.MULT_LAT(5), .DIV_LAT(10), .HANDLER(32'h0000_4180)) dut (
    .clk(clk), .reset(reset),
    .grfRa1_D(grfRa1_D), .grfRa2_D(grfRa2_D),
    .ifReGrf1_D(ifReGrf1_D), .ifReGrf2_D(ifReGrf2_D),
    .tUseRs_D(tUseRs_D), .tUseRt_D(tUseRt_D),
    .grfWa_Ex(grfWa_Ex), .grfWa_Mem(grfWa_Mem),
    .ifWrGrf_Ex(ifWrGrf_Ex), .ifWrGrf_Mem(ifWrGrf_Mem),
    .tNew_Ex(tNew_Ex), .tNew_Mem(tNew_Mem),
    .mdUse_D(mdUse_D), .mdStart_Ex(mdStart_Ex), .mdIsDiv_Ex(mdIsDiv_Ex),
    .excReq_Mem(excReq_Mem), .eret_Mem(eret_Mem), .epc(epc),
    .stall_F(stall_F), .stall_D(stall_D), .flush_D(flush_D),
    .flush_Ex(flush_Ex), .flush_Mem(flush_Mem), .redirect(redirect),
    .redirectPc(redirectPc), .mdBusy(mdBusy)
  );

  // Expected-vector packer: {stall_F, stall_D, flush_D, flush_Ex, flush_Mem, redirect, mdBusy, redirectPc}
  function automatic logic [38:0] ev(input logic sF, input logic sD, input logic fD,
                                     input logic fE, input logic fM, input logic rd,
                                     input logic bz, input logic [31:0] pc);
    return {sF, sD, fD, fE, fM, rd, bz, pc};
  endfunction

  localparam logic [38:0] IDLE  = 39'd0;
  localparam logic [38:0] STALL = {7'b1101000, 32'd0};

  task automatic clear_inputs();
    grfRa1_D = 0; grfRa2_D = 0; tUseRs_D = 0; tUseRt_D = 0;
    ifReGrf1_D = 0; ifReGrf2_D = 0;
    grfWa_Ex = 0; grfWa_Mem = 0; tNew_Ex = 0; tNew_Mem = 0;
    ifWrGrf_Ex = 0; ifWrGrf_Mem = 0;
    mdUse_D = 0; mdStart_Ex = 0; mdIsDiv_Ex = 0;
    excReq_Mem = 0; eret_Mem = 0; epc = 0;
  endtask

  // Inputs already applied; queue the expectation and advance one cycle.
  task automatic step(input string nm, input logic [38:0] e);
    exp_q.push_back(e);
    name_q.push_back(nm);
    @(posedge clk);
    #1;
  endtask

  // Monitor: compares the DUT outputs mid-cycle against the queued expectation.
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      logic [38:0] e, a;
      string nm;
      e  = exp_q.pop_front();
      nm = name_q.pop_front();
      a  = {stall_F, stall_D, flush_D, flush_Ex, flush_Mem, redirect, mdBusy, redirectPc};
      checks++;
      if (a !== e) begin
        failures++;
        $display("FAIL %s: got sF/sD/fD/fE/fM/rd/bz=%b pc=%h, want %b pc=%h",
                 nm, a[38:32], a[31:0], e[38:32], e[31:0]);
      end
    end
  end

  initial begin
    reset = 1'b1;
    clear_inputs();
    // Hazard and exception present during reset: outputs must still be zero.
    excReq_Mem = 1; ifReGrf1_D = 1; grfRa1_D = 1; ifWrGrf_Ex = 1; grfWa_Ex = 1; tNew_Ex = 2;
    mdStart_Ex = 1; mdUse_D = 1;
    @(posedge clk); #1;
    step("reset_forced_zero", IDLE);
    step("reset_forced_zero2", IDLE);
    reset = 1'b0;
    clear_inputs();
    step("run_idle", IDLE);

    // 1: lw at E, addu reads $1 in D
    ifReGrf1_D = 1; grfRa1_D = 1; tUseRs_D = 1;
    ifWrGrf_Ex = 1; grfWa_Ex = 1; tNew_Ex = 2;
    step("lw_use_stall_E", STALL);
    ifWrGrf_Ex = 0; ifWrGrf_Mem = 1; grfWa_Mem = 1; tNew_Mem = 1;
    step("lw_at_M_released", IDLE);
    // tNew == tUse at E: forwarding suffices
    clear_inputs();
    ifReGrf1_D = 1; grfRa1_D = 3; tUseRs_D = 1; ifWrGrf_Ex = 1; grfWa_Ex = 3; tNew_Ex = 1;
    step("tnew_eq_tuse_nostall", IDLE);
    // rt hazard against M stage
    clear_inputs();
    ifReGrf2_D = 1; grfRa2_D = 5; tUseRt_D = 0; ifWrGrf_Mem = 1; grfWa_Mem = 5; tNew_Mem = 1;
    step("rt_mem_stall", STALL);
    // rt address matches but rt not read
    ifReGrf2_D = 0;
    step("rt_not_read_nostall", IDLE);

    // 2: $0 never stalls
    clear_inputs();
    ifReGrf1_D = 1; grfRa1_D = 0; ifWrGrf_Ex = 1; grfWa_Ex = 0; tNew_Ex = 2;
    step("zero_reg_nostall", IDLE);

    // 3: div at E with mflo in D -> 11 busy/stall cycles, proceeds on 12th
    clear_inputs();
    mdStart_Ex = 1; mdIsDiv_Ex = 1; mdUse_D = 1;
    step("div_start_stall", ev(1,1,0,1,0,0,1,0));
    mdStart_Ex = 0; mdIsDiv_Ex = 0;
    for (int i = 1; i <= 10; i++) step($sformatf("div_busy_%0d", i), ev(1,1,0,1,0,0,1,0));
    step("div_done_mflo_go", IDLE);
    // mult: busy 6 cycles (start + 5), no stall without an md consumer
    clear_inputs();
    mdStart_Ex = 1;
    step("mult_start_busy", ev(0,0,0,0,0,0,1,0));
    mdStart_Ex = 0;
    for (int i = 1; i <= 5; i++) step($sformatf("mult_busy_%0d", i), ev(0,0,0,0,0,0,1,0));
    step("mult_done", IDLE);

    // 4: exception with a data stall active; next cycle excReq is ignored
    clear_inputs();
    ifReGrf1_D = 1; grfRa1_D = 1; tUseRs_D = 1; ifWrGrf_Ex = 1; grfWa_Ex = 1; tNew_Ex = 2;
    excReq_Mem = 1;
    step("exc_overrides_stall", ev(0,0,1,1,1,1,0,32'h0000_4180));
    step("redir_ignores_exc", STALL);
    clear_inputs();
    step("back_to_run", IDLE);

    // 5: exception kills a same-cycle mult/div start
    excReq_Mem = 1; mdStart_Ex = 1; mdIsDiv_Ex = 1;
    step("exc_kills_mdstart", ev(0,0,1,1,1,1,0,32'h0000_4180));
    clear_inputs();
    step("killed_md_not_busy", IDLE);

    // exception wins over simultaneous eret
    excReq_Mem = 1; eret_Mem = 1; epc = 32'h0000_3010;
    step("exc_beats_eret", ev(0,0,1,1,1,1,0,32'h0000_4180));
    clear_inputs();
    step("redir_after_both", IDLE);

    // 6: eret to epc; eret in REDIR ignored
    eret_Mem = 1; epc = 32'h0000_3010;
    step("eret_redirect", ev(0,0,1,1,1,1,0,32'h0000_3010));
    step("redir_ignores_eret", IDLE);
    clear_inputs();
    step("run_after_eret", IDLE);

    // reset while div busy abandons it
    mdStart_Ex = 1; mdIsDiv_Ex = 1;
    step("div_start2", ev(0,0,0,0,0,0,1,0));
    clear_inputs();
    step("div_busy2", ev(0,0,0,0,0,0,1,0));
    reset = 1'b1;
    step("reset_midop_zero", IDLE);
    reset = 1'b0;
    step("after_reset_not_busy", IDLE);

    // Drain the scoreboard with a bounded wait.
    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(negedge clk);
    #1;
    if (exp_q.size() > 0) begin
      failures++;
      $display("FAIL drain: %0d expectations left, want 0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
